// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and helpers for the keypad BCD decode path.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic digit_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 from digits of 8 or more.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per cycle,
// with a start/busy/done handshake.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [4*N_DIGITS-1:0]   bin_out
);

    localparam int W     = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    conv_state_t      state, state_next;
    logic [2*W-1:0]   sr;
    logic [2*W-1:0]   sr_shift;
    logic [2*W-1:0]   sr_adj;
    logic [CNT_W-1:0] cnt;
    logic             all_valid;
    logic             last_iter;

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!digit_valid(bcd_in[4*i +: 4])) all_valid = 1'b0;
        end
    end

    // Shift first, then correct every BCD digit of the upper half independently.
    assign sr_shift = sr >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (sr_shift[W + 4*g +: 4]),
            .adj   (sr_adj[W + 4*g +: 4])
        );
    end

    assign sr_adj[W-1:0] = sr_shift[W-1:0];
    assign last_iter     = (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = all_valid ? SHIFT : DONE;
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (all_valid) begin
                            sr  <= {bcd_in, {W{1'b0}}};
                            cnt <= '0;
                            err <= 1'b0;
                        end else begin
                            err     <= 1'b1;
                            bin_out <= '0;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) bin_out <= sr_adj[W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq against a decimal-arithmetic reference.
module tb_bcd_to_bin_seq;

    localparam int N_DIGITS = 4;
    localparam int W        = 4 * N_DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] bcd_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] bin_out;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.N_DIGITS(N_DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal value of the packed digits; invalid digit gives 0 with bad set.
    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] bcd, output logic bad);
        int v;
        int scale;
        int d;
        v     = 0;
        scale = 1;
        bad   = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            v     += d * scale;
            scale *= 10;
        end
        return bad ? '0 : W'(v);
    endfunction

    // One start pulse; optionally a stray start (bcd 0x0001) at cycle inject_k while busy.
    task automatic conv(input logic [W-1:0] bcd, input int inject_k, input string tag);
        logic         bad;
        logic [W-1:0] exp_bin;
        int           k;
        int           pulses;
        exp_bin = ref_bin(bcd, bad);
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = W'($urandom);
        k = 1;
        while (!done && k < 40) begin
            check_val({tag, " busy"}, 32'(busy), 32'd1);
            if (k == inject_k) begin
                start  = 1'b1;
                bcd_in = 16'h0001;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_val({tag, " latency"}, 32'(k), bad ? 32'd1 : 32'(W + 1));
        check_val({tag, " done"}, 32'(done), 32'd1);
        check_val({tag, " busy at done"}, 32'(busy), 32'd1);
        check_val({tag, " bin_out"}, 32'(bin_out), 32'(exp_bin));
        check_val({tag, " err"}, 32'(err), 32'(bad));
        @(negedge clk);
        check_val({tag, " done width"}, 32'(done), 32'd0);
        check_val({tag, " idle busy"}, 32'(busy), 32'd0);
        if (inject_k > 0) begin
            pulses = 0;
            repeat (25) begin
                @(negedge clk);
                if (done) pulses++;
            end
            check_val({tag, " extra done"}, 32'(pulses), 32'd0);
            check_val({tag, " held bin_out"}, 32'(bin_out), 32'(exp_bin));
        end
    endtask

    initial begin
        logic [W-1:0] rnd;
        int           k1;
        int           k2;
        int           k;
        int           pulses;

        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #12;
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset err", 32'(err), 32'd0);
        check_val("reset bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        conv(16'h1234, 0, "basic 1234");
        conv(16'h9999, 0, "max 9999");
        conv(16'h0000, 0, "zero");
        conv(16'h0008, 0, "eight");
        conv(16'h1000, 0, "thousand");
        conv(16'h12A4, 0, "invalid 12A4");
        conv(16'h0042, 0, "after invalid 0042");
        conv(16'h0500, 5, "start while busy 0500");

        // Held start: back-to-back conversions one IDLE cycle apart.
        @(negedge clk);
        bcd_in = 16'h0042;
        start  = 1'b1;
        k  = 0;
        k1 = -1;
        k2 = -1;
        while (k2 < 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (k1 < 0) k1 = k;
                else        k2 = k;
            end
        end
        start = 1'b0;
        check_val("b2b first latency", 32'(k1), 32'(W + 1));
        check_val("b2b spacing", 32'(k2 - k1), 32'(W + 2));
        check_val("b2b bin_out", 32'(bin_out), 32'h002A);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-conversion.
        bcd_in = 16'h4321;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("midreset busy", 32'(busy), 32'd0);
        check_val("midreset done", 32'(done), 32'd0);
        check_val("midreset err", 32'(err), 32'd0);
        check_val("midreset bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("midreset no done", 32'(pulses), 32'd0);
        conv(16'h0007, 0, "after reset 0007");

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N_DIGITS; i++) rnd[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) rnd[4*$urandom_range(0, N_DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            conv(rnd, 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
